// File: rtl/pb_varint_stream_decoder.sv
// Streaming protobuf base-128 varint / message-key decoder, one byte per cycle.
// Optional zigzag decoding is enabled by defining PB_VARINT_ZIGZAG_EN.
module pb_varint_stream_decoder #(
  parameter int OUT_W     = 64,
  parameter int MAX_BYTES = 10,
  localparam int NB_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_key,
`ifdef PB_VARINT_ZIGZAG_EN
  input  logic             in_zigzag,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_value,
  output logic [28:0]      out_field,
  output logic [2:0]       out_wire,
  output logic [NB_W-1:0]  out_nbytes,
  output logic             out_err
);

  localparam int WIDE = MAX_BYTES * 7;
  localparam logic [0:0] ACCUM   = 1'b0;
  localparam logic [0:0] DISCARD = 1'b1;
  localparam logic [WIDE-1:0] LO_MASK = WIDE'({OUT_W{1'b1}});

  logic [0:0]       state;
  logic [OUT_W-1:0] acc;
  logic [NB_W-1:0]  count;
  logic             err;
  logic             key_r;
`ifdef PB_VARINT_ZIGZAG_EN
  logic             zz_r;
`endif

  logic             take_in;
  logic             term;
  logic             first;
  logic             cur_key;
  logic             cur_zz;
  logic [WIDE-1:0]  shifted;
  logic             ovf;
  logic [OUT_W-1:0] acc_next;
  logic [OUT_W-1:0] raw_val;
  logic [OUT_W-1:0] fin_val;
  logic [31:0]      val32;
  logic             key_bad;
  logic             fin_err;
  logic [NB_W-1:0]  fin_nbytes;

  assign in_ready = !out_valid || out_ready;
  assign take_in  = in_valid && in_ready;
  assign term     = take_in && !in_data[7];

  always_comb begin
    first   = (state == ACCUM) && (count == '0);
    cur_key = first ? in_key : key_r;
`ifdef PB_VARINT_ZIGZAG_EN
    cur_zz  = first ? in_zigzag : zz_r;
`else
    cur_zz  = 1'b0;
`endif
    // Payload is placed in a MAX_BYTES*7 wide window so bits past OUT_W can be inspected.
    shifted  = WIDE'(in_data[6:0]) << (7 * int'(count));
    ovf      = |(shifted & ~LO_MASK);
    acc_next = acc | shifted[OUT_W-1:0];
    raw_val  = (state == ACCUM) ? acc_next : acc;

    if (state == ACCUM) begin
      fin_nbytes = count + 1'b1;
      fin_err    = err | ovf;
    end else begin
      fin_nbytes = NB_W'(MAX_BYTES);
      fin_err    = 1'b1;
    end

    val32   = 32'(raw_val);
    key_bad = (val32[31:3] == '0) || ((raw_val >> 32) != '0) || (val32[2:1] == 2'b11);
    if (cur_key) fin_err = fin_err | key_bad;

    fin_val = raw_val;
    if (!cur_key && cur_zz) fin_val = (raw_val >> 1) ^ {OUT_W{raw_val[0]}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
      acc   <= '0;
      count <= '0;
      err   <= 1'b0;
      key_r <= 1'b0;
`ifdef PB_VARINT_ZIGZAG_EN
      zz_r  <= 1'b0;
`endif
    end else if (take_in) begin
      if (first) begin
        key_r <= in_key;
`ifdef PB_VARINT_ZIGZAG_EN
        zz_r  <= in_zigzag;
`endif
      end
      if (!in_data[7]) begin
        state <= ACCUM;
        acc   <= '0;
        count <= '0;
        err   <= 1'b0;
      end else if (state == ACCUM) begin
        acc <= acc_next;
        // Last permitted byte still carries a continuation: keep acc, drop the rest.
        if (count == NB_W'(MAX_BYTES - 1)) begin
          err   <= 1'b1;
          state <= DISCARD;
        end else begin
          count <= count + 1'b1;
          err   <= err | ovf;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_value  <= '0;
      out_field  <= '0;
      out_wire   <= '0;
      out_nbytes <= '0;
      out_err    <= 1'b0;
    end else if (term) begin
      out_valid  <= 1'b1;
      out_value  <= fin_val;
      out_field  <= cur_key ? val32[31:3] : '0;
      out_wire   <= cur_key ? val32[2:0] : '0;
      out_nbytes <= fin_nbytes;
      out_err    <= fin_err;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
